biriscv_fetch_mq: RTL



---
 rtl/biriscv_fetch_mq_pkg.sv | 13 +
 rtl/biriscv_fetch_mq_fifo.sv | 50 +++++
 rtl/biriscv_fetch_mq.sv | 107 ++++++++++
 3 files changed

// File: rtl/biriscv_fetch_mq_pkg.sv
// biriscv_defs: privilege levels and the 100-bit fetch response entry shared by the fetch unit.
package biriscv_defs;
   localparam logic [1:0] PRIV_USER    = 2'd0;
   localparam logic [1:0] PRIV_SUPER   = 2'd1;
   localparam logic [1:0] PRIV_MACHINE = 2'd3;
   typedef struct packed {
      logic        page_fault;
      logic        error;
      logic [1:0]  pred;
      logic [31:0] pc;
      logic [63:0] inst;
   } fetch_rsp_t;
endpackage

// File: rtl/biriscv_fetch_mq_fifo.sv
// biriscv_fetch_fifo: synchronous FIFO with flush and fill level; head reads as zero when empty.
module biriscv_fetch_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 2,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic [LW-1:0]    level_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [LW-1:0]    level_q;
   logic             push, pop;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   assign push    = push_i & (32'(level_q) < DEPTH);
   assign pop     = pop_i & valid_o;
   assign valid_o = level_q != '0;
   assign data_o  = valid_o ? mem_q[rd_q] : '0;
   assign level_o = level_q;

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         level_q <= '0;
      end else if (flush_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         level_q <= '0;
      end else begin
         if (push) wr_q <= inc(wr_q);
         if (pop) rd_q <= inc(rd_q);
         level_q <= level_q + LW'(push) - LW'(pop);
      end

   always_ff @(posedge clk_i)
      if (push) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/biriscv_fetch_mq.sv
// biriscv_fetch_mq: multi-outstanding icache fetch with credit-reserved response queue and drop counting.
// BIRISCV_FETCH_PRIV_EN enables privilege tracking from branch_priv_i; otherwise machine mode is driven.
module biriscv_fetch_mq
   import biriscv_defs::*;
#(
   parameter int OUTSTANDING = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        branch_request_i,
   input  logic [31:0] branch_pc_i,
   input  logic [1:0]  branch_priv_i,
   input  logic [31:0] next_pc_f_i,
   input  logic [1:0]  next_taken_f_i,
   input  logic        fetch_invalidate_i,
   input  logic        icache_accept_i,
   input  logic        icache_valid_i,
   input  logic        icache_error_i,
   input  logic        icache_page_fault_i,
   input  logic [63:0] icache_inst_i,
   output logic        icache_rd_o,
   output logic [31:0] icache_pc_o,
   output logic [1:0]  icache_priv_o,
   output logic        icache_flush_o,
   output logic [31:0] pc_f_o,
   output logic        pc_accept_o,
   output logic        fetch_valid_o,
   input  logic        fetch_accept_i,
   output logic [63:0] fetch_instr_o,
   output logic [31:0] fetch_pc_o,
   output logic [1:0]  fetch_pred_branch_o,
   output logic        fetch_fault_fetch_o,
   output logic        fetch_fault_page_o
);
   logic                                 active_q;
   logic [31:0]                          pc_f_q, pc_f_d;
   logic [2:0]                           inflight_q, inflight_d, drop_q, drop_d;
   logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count;
   logic [$clog2(OUTSTANDING+1)-1:0]     unused_tag_level;
   logic                                 unused_tag_valid;
   logic [33:0]                          tag_head;
   fetch_rsp_t                           rsp_in, rsp_head;
   logic                                 rsp_push;

   // Credit check counts in-flight requests against free queue slots so responses never overflow.
   assign icache_rd_o = active_q & ~branch_request_i & ~fetch_invalidate_i
                      & (32'(inflight_q) < OUTSTANDING)
                      & (32'(inflight_q) + 32'(fifo_count) < FIFO_DEPTH);
   assign pc_accept_o    = icache_rd_o & icache_accept_i;
   assign icache_pc_o    = {pc_f_q[31:3], 3'b0};
   assign pc_f_o         = pc_f_q;
   assign icache_flush_o = fetch_invalidate_i;

   assign pc_f_d     = branch_request_i ? branch_pc_i : pc_accept_o ? next_pc_f_i : pc_f_q;
   assign inflight_d = inflight_q + {2'b0, pc_accept_o} - {2'b0, icache_valid_i};
   assign drop_d     = branch_request_i ? inflight_q - {2'b0, icache_valid_i}
                                        : drop_q - {2'b0, icache_valid_i && drop_q != '0};
   assign rsp_push   = icache_valid_i & (drop_q == '0);
   assign rsp_in     = '{page_fault: icache_page_fault_i, error: icache_error_i,
                         pred: tag_head[1:0], pc: tag_head[33:2], inst: icache_inst_i};

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         active_q   <= 1'b0;
         pc_f_q     <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         active_q   <= active_q | branch_request_i;
         pc_f_q     <= pc_f_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end

`ifdef BIRISCV_FETCH_PRIV_EN
   logic [1:0] priv_q;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) priv_q <= PRIV_MACHINE;
      else if (branch_request_i) priv_q <= branch_priv_i;
   assign icache_priv_o = priv_q;
`else
   logic unused_priv;
   assign unused_priv   = ^branch_priv_i;
   assign icache_priv_o = PRIV_MACHINE;
`endif

   biriscv_fetch_fifo #(.WIDTH(34), .DEPTH(OUTSTANDING)) u_tag (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(1'b0),
      .push_i(pc_accept_o), .data_i({pc_f_q, next_taken_f_i}),
      .pop_i(icache_valid_i), .data_o(tag_head),
      .valid_o(unused_tag_valid), .level_o(unused_tag_level)
   );

   biriscv_fetch_fifo #(.WIDTH($bits(fetch_rsp_t)), .DEPTH(FIFO_DEPTH)) u_rsp (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(branch_request_i),
      .push_i(rsp_push), .data_i(rsp_in),
      .pop_i(fetch_valid_o & fetch_accept_i), .data_o(rsp_head),
      .valid_o(fetch_valid_o), .level_o(fifo_count)
   );

   assign fetch_instr_o       = rsp_head.inst;
   assign fetch_pc_o          = rsp_head.pc;
   assign fetch_pred_branch_o = rsp_head.pred;
   assign fetch_fault_fetch_o = rsp_head.error;
   assign fetch_fault_page_o  = rsp_head.page_fault;
endmodule
